// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - datapath/control bundle between the multi-cycle controller and its datapath
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       jr;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, jr, zero, mem_ready,
        output pc_write, pc_source, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               illegal, state
    );

    modport slave (
        output opcode, jr, zero, mem_ready,
        input  pc_write, pc_source, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               illegal, state
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with memory wait timeout
// Optional performance counters: define CTRL_PERF_CNT_EN.
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     instr_count,
    output logic [CNT_W-1:0]     cycle_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ      = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ANDI_EX  = 4'd11,
        S_ORI_EX   = 4'd12,
        S_IMM_WB   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam int           WCW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit           TO_EN = (TIMEOUT > 0);
    localparam logic [WCW-1:0] WLIM = WCW'(TIMEOUT - 1);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
    if (TIMEOUT < 0) begin : g_bad_timeout
        $error("TIMEOUT must not be negative");
    end

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_cnt;
    logic           wait_state;
    logic           timeout_hit;
    logic           abort;

    assign wait_state  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout_hit = TO_EN && wait_state && !bus.mem_ready && (wait_cnt == WLIM);
    assign bus.state   = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            // Counter is per-visit: any exit (normal or abort) restarts it.
            if (!wait_state || (state_d != state_q) || timeout_hit) begin
                wait_cnt <= '0;
            end else if (!bus.mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        abort          = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_source  = 2'b00;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 3'b000;

        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.pc_write  = bus.mem_ready;
                bus.ir_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_ANDI:      state_d = S_ANDI_EX;
                    OP_ORI:       state_d = S_ORI_EX;
                    default: begin
                        abort   = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.iord     = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                bus.iord      = 1'b1;
                bus.mem_write = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_RTYPE_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 3'b010;
                if (bus.jr) begin
                    bus.pc_source = 2'b11;
                    bus.pc_write  = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    state_d = S_RTYPE_WB;
                end
            end
            S_RTYPE_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 3'b001;
                bus.pc_source = 2'b01;
                bus.pc_write  = bus.zero;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_source = 2'b10;
                bus.pc_write  = 1'b1;
                state_d       = S_FETCH;
            end
            S_ADDI_EX, S_ANDI_EX, S_ORI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = (state_q == S_ANDI_EX) ? 3'b100 :
                                (state_q == S_ORI_EX)  ? 3'b101 : 3'b000;
                state_d       = S_IMM_WB;
            end
            S_IMM_WB: begin
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (timeout_hit) begin
            abort   = 1'b1;
            state_d = S_FETCH;
        end
        bus.illegal = abort;

        // State is already FETCH during reset, but its mem_ready-driven enables must not leak out.
        if (reset) begin
            bus.pc_write  = 1'b0;
            bus.ir_write  = 1'b0;
            bus.reg_write = 1'b0;
            bus.mem_write = 1'b0;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
            if ((state_q != S_FETCH) && (state_d == S_FETCH) && !abort) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;
    localparam int TO = 4;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2, S_MEMRD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4,  S_MEMWR  = 4'd5,  S_REX    = 4'd6, S_RWB   = 4'd7;
    localparam logic [3:0] S_BEQ   = 4'd8,  S_JUMP   = 4'd9,  S_ADDI   = 4'd10, S_ANDI = 4'd11;
    localparam logic [3:0] S_ORI   = 4'd12, S_IMMWB  = 4'd13;

    // {pc_write, pc_source, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal}
    function automatic logic [16:0] v(bit pcw, logic [1:0] pcs, bit iord, bit mr, bit mw, bit irw,
                                      bit rd, bit m2r, bit rw, bit asa, logic [1:0] asb,
                                      logic [2:0] aop, bit ill);
        return {pcw, pcs, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ill};
    endfunction

    localparam logic [16:0] V_FGO   = v(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000, 0);
    localparam logic [16:0] V_FW    = v(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 0);
    localparam logic [16:0] V_FTO   = v(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 1);
    localparam logic [16:0] V_DEC   = v(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 0);
    localparam logic [16:0] V_DILL  = v(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 1);
    localparam logic [16:0] V_MA    = v(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0);
    localparam logic [16:0] V_MRD   = v(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    localparam logic [16:0] V_MRDTO = v(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1);
    localparam logic [16:0] V_MWB   = v(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 0);
    localparam logic [16:0] V_MWR0  = v(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    localparam logic [16:0] V_MWR1  = v(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    localparam logic [16:0] V_REX   = v(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 0);
    localparam logic [16:0] V_JR    = v(1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 0);
    localparam logic [16:0] V_RWB   = v(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 0);
    localparam logic [16:0] V_BEQ1  = v(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 0);
    localparam logic [16:0] V_BEQ0  = v(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 0);
    localparam logic [16:0] V_JMP   = v(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    localparam logic [16:0] V_IWB   = v(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 0);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if bus();
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_count, cycle_count;
`endif

    multicycle_control #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CTRL_PERF_CNT_EN
        ,
        .instr_count (instr_count),
        .cycle_count (cycle_count)
`endif
    );

    typedef struct {
        logic [3:0]  st;
        logic [16:0] ctl;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_instr = 0;
    int   exp_cyc = 0;
    bit   rst_prev = 1'b1;
    logic [5:0] cur_op = '0;
    bit   cur_jr = 1'b0;
    bit   cur_z  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit rst, input logic [5:0] op, input bit j, input bit z, input bit mr,
                       input logic [3:0] st, input logic [16:0] ctl, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.opcode    = op;
        bus.jr        = j;
        bus.zero      = z;
        bus.mem_ready = mr;
        if (rst) begin
            exp_cyc  = 0;
            rst_prev = 1'b1;
        end else if (rst_prev) begin
            rst_prev = 1'b0;
        end else begin
            exp_cyc++;
        end
        e.st  = st;
        e.ctl = ctl;
        e.tag = tag;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic c(input bit mr, input logic [3:0] st, input logic [16:0] ctl, input string tag);
        cyc(1'b0, cur_op, cur_jr, cur_z, mr, st, ctl, tag);
    endtask

    task automatic start(input logic [5:0] op, input bit j, input bit z, input string tag);
        cur_op = op;
        cur_jr = j;
        cur_z  = z;
        c(1'b1, S_FETCH, V_FGO, {tag, "_f"});
        c(1'b1, S_DECODE, V_DEC, {tag, "_d"});
    endtask

    task automatic imm(input logic [5:0] op, input logic [3:0] st, input logic [2:0] aop, input string tag);
        start(op, 1'b0, 1'b0, tag);
        c(1'b1, st, v(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, aop, 0), {tag, "_ex"});
        c(1'b1, S_IMMWB, V_IWB, {tag, "_wb"});
        exp_instr++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({e.tag, "_st"}, {28'd0, bus.state}, {28'd0, e.st});
            check({e.tag, "_ctl"},
                  {15'd0, bus.pc_write, bus.pc_source, bus.iord, bus.mem_read, bus.mem_write,
                   bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                   bus.alu_src_b, bus.alu_op, bus.illegal},
                  {15'd0, e.ctl});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode    = '0;
        bus.jr        = 1'b0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;

        cyc(1'b1, 6'b000000, 0, 0, 1'b1, S_FETCH, V_FW, "reset");

        // reset mid-MEMRD: async return to FETCH, no writeback afterwards
        start(6'b100011, 1'b0, 1'b0, "lwrst");
        c(1'b1, S_MEMADR, V_MA, "lwrst_ma");
        c(1'b0, S_MEMRD, V_MRD, "lwrst_rd");
        cyc(1'b1, 6'b100011, 0, 0, 1'b0, S_FETCH, V_FW, "rst_mid");
        c(1'b0, S_FETCH, V_FW, "rst_after");

        start(6'b000000, 1'b0, 1'b0, "add");
        c(1'b1, S_REX, V_REX, "add_ex");
        c(1'b1, S_RWB, V_RWB, "add_wb");
        exp_instr++;

        // lw with 3 wait cycles; mem_ready arrives exactly at the timeout limit
        start(6'b100011, 1'b0, 1'b0, "lw");
        c(1'b1, S_MEMADR, V_MA, "lw_ma");
        for (int i = 0; i < 3; i++) c(1'b0, S_MEMRD, V_MRD, "lw_wait");
        c(1'b1, S_MEMRD, V_MRD, "lw_rd");
        c(1'b1, S_MEMWB, V_MWB, "lw_wb");
        exp_instr++;

        start(6'b101011, 1'b0, 1'b0, "sw");
        c(1'b1, S_MEMADR, V_MA, "sw_ma");
        c(1'b0, S_MEMWR, V_MWR0, "sw_wait");
        c(1'b1, S_MEMWR, V_MWR1, "sw_wr");
        exp_instr++;

        start(6'b000100, 1'b0, 1'b1, "beqt");
        c(1'b1, S_BEQ, V_BEQ1, "beqt_ex");
        exp_instr++;
        start(6'b000100, 1'b0, 1'b0, "beqn");
        c(1'b1, S_BEQ, V_BEQ0, "beqn_ex");
        exp_instr++;

        start(6'b000010, 1'b0, 1'b0, "j");
        c(1'b1, S_JUMP, V_JMP, "j_ex");
        exp_instr++;

        start(6'b000000, 1'b1, 1'b0, "jr");
        c(1'b1, S_REX, V_JR, "jr_ex");
        exp_instr++;

        imm(6'b001000, S_ADDI, 3'b000, "addi");
        imm(6'b001100, S_ANDI, 3'b100, "andi");
        imm(6'b001101, S_ORI,  3'b101, "ori");

        cur_op = 6'b111111;
        cur_jr = 1'b0;
        c(1'b1, S_FETCH, V_FGO, "ill_f");
        c(1'b1, S_DECODE, V_DILL, "ill_d");

        // FETCH timeout: illegal on the 4th stalled cycle, then a fresh FETCH
        for (int i = 0; i < TO - 1; i++) c(1'b0, S_FETCH, V_FW, "fto_wait");
        c(1'b0, S_FETCH, V_FTO, "fto_hit");

        start(6'b100011, 1'b0, 1'b0, "lwto");
        c(1'b1, S_MEMADR, V_MA, "lwto_ma");
        for (int i = 0; i < TO - 1; i++) c(1'b0, S_MEMRD, V_MRD, "lwto_wait");
        c(1'b0, S_MEMRD, V_MRDTO, "lwto_hit");

        start(6'b000000, 1'b0, 1'b0, "add2");
        c(1'b1, S_REX, V_REX, "add2_ex");
        c(1'b1, S_RWB, V_RWB, "add2_wb");
        exp_instr++;
        c(1'b0, S_FETCH, V_FW, "end");

`ifdef CTRL_PERF_CNT_EN
        check("instr_count", instr_count, exp_instr);
        check("cycle_count", cycle_count, exp_cyc);
`endif

        @(posedge clk);
        check("sb_drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
